prvp_spi_master_axi_slave_plug: RTL and testbench

// - AXI4 slave endpoint on the initiating chip of the C2C SPI link; counterpart of the SPI-slave-side AXI master plug.
// - Converts single-beat AXI reads/writes into 32-bit word frames (cmd, addr, data) for the SPI master serializer.
// - Returns read words and B responses to the AXI master. One transaction in flight.

---
 rtl/prvp_c2c_pkg.sv | 23 ++
 rtl/prvp_spi_master_axi_slave_plug.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_prvp_spi_master_axi_slave_plug.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prvp_c2c_pkg.sv
// Shared constants and FSM state encoding for the C2C SPI link AXI plugs.
package prvp_c2c_pkg;

   localparam logic [7:0]  OPC_WRITE    = 8'h02;
   localparam logic [7:0]  OPC_READ     = 8'h0B;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [3:0] {
      IDLE,
      WDATA,
      TXCMD,
      TXADDR,
      TXDATA,
      RXWAIT,
      BRESP,
      RRESP,
      WDRAIN,
      RERR
   } state_e;

endpackage

// File: rtl/prvp_spi_master_axi_slave_plug.sv
// AXI4 single-beat slave that turns each access into cmd/addr/data word frames
// for the SPI master serializer and returns the read word or write response.
module prvp_spi_master_axi_slave_plug
   import prvp_c2c_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6,
   parameter int AXI_ID_WIDTH   = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        axi_aclk,
   input  logic                        axi_aresetn,
   input  logic                        axi_slave_aw_valid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
   input  logic [7:0]                  axi_slave_aw_len,
   input  logic [2:0]                  axi_slave_aw_size,
   input  logic [1:0]                  axi_slave_aw_burst,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
   output logic                        axi_slave_aw_ready,
   input  logic                        axi_slave_w_valid,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
   input  logic                        axi_slave_w_last,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
   output logic                        axi_slave_w_ready,
   output logic                        axi_slave_b_valid,
   output logic [1:0]                  axi_slave_b_resp,
   output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
   output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
   input  logic                        axi_slave_b_ready,
   input  logic                        axi_slave_ar_valid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
   input  logic [7:0]                  axi_slave_ar_len,
   input  logic [2:0]                  axi_slave_ar_size,
   input  logic [1:0]                  axi_slave_ar_burst,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
   output logic                        axi_slave_ar_ready,
   output logic                        axi_slave_r_valid,
   output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
   output logic [1:0]                  axi_slave_r_resp,
   output logic                        axi_slave_r_last,
   output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
   output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user,
   input  logic                        axi_slave_r_ready,
   output logic [31:0]                 tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   input  logic [31:0]                 rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output logic                        busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam int REPL  = AXI_DATA_WIDTH / 32;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                      state_q, state_d;
   logic                        prio_q, prio_d;
   logic                        aw_ready_q, aw_ready_d;
   logic                        ar_ready_q, ar_ready_d;
   logic                        is_write_q, is_write_d;
   logic [31:0]                 addr_q, addr_d;
   logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
   logic [7:0]                  len_q, len_d;
   logic [7:0]                  beat_q, beat_d;
   logic [CNT_W-1:0]            tmo_q, tmo_d;
   logic [31:0]                 word_q, word_d;
   logic [31:0]                 tx_data_q, tx_data_d;
   logic [1:0]                  b_resp_q, b_resp_d;
   logic [AXI_ID_WIDTH-1:0]     b_id_q, b_id_d;
   logic [AXI_DATA_WIDTH-1:0]   r_data_q, r_data_d;
   logic [1:0]                  r_resp_q, r_resp_d;
   logic                        r_last_q, r_last_d;
   logic [AXI_ID_WIDTH-1:0]     r_id_q, r_id_d;

   logic                        lane_sel;
   logic [AXI_DATA_WIDTH-1:0]   w_shift;
   logic [AXI_DATA_WIDTH/8-1:0] strb_shift;
   logic                        unused_inputs;

   // On a 64-bit bus the upper lane carries the word when addr[2] is set
   assign lane_sel   = (AXI_DATA_WIDTH == 64) ? addr_q[2] : 1'b0;
   assign w_shift    = axi_slave_w_data >> {lane_sel, 5'd0};
   assign strb_shift = axi_slave_w_strb >> {lane_sel, 2'd0};

   assign unused_inputs = ^{axi_slave_aw_burst, axi_slave_ar_burst, axi_slave_aw_user,
                            axi_slave_ar_user, axi_slave_w_user, axi_slave_w_last};

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      aw_ready_d = 1'b0;
      ar_ready_d = 1'b0;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      id_d       = id_q;
      len_d      = len_q;
      beat_d     = beat_q;
      tmo_d      = tmo_q;
      word_d     = word_q;
      tx_data_d  = tx_data_q;
      b_resp_d   = b_resp_q;
      b_id_d     = b_id_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      r_last_d   = r_last_q;
      r_id_d     = r_id_q;

      case (state_q)
         IDLE: begin
            if (aw_ready_q && axi_slave_aw_valid) begin
               addr_d     = axi_slave_aw_addr[31:0];
               id_d       = axi_slave_aw_id;
               len_d      = axi_slave_aw_len;
               beat_d     = 8'd0;
               is_write_d = 1'b1;
               state_d    = ((axi_slave_aw_len != 8'd0) || (axi_slave_aw_size > 3'd2)) ? WDRAIN : WDATA;
            end else if (ar_ready_q && axi_slave_ar_valid) begin
               addr_d     = axi_slave_ar_addr[31:0];
               id_d       = axi_slave_ar_id;
               len_d      = axi_slave_ar_len;
               beat_d     = 8'd0;
               is_write_d = 1'b0;
               if ((axi_slave_ar_len != 8'd0) || (axi_slave_ar_size > 3'd2)) begin
                  r_data_d = '0;
                  r_resp_d = RESP_SLVERR;
                  r_last_d = (axi_slave_ar_len == 8'd0);
                  r_id_d   = axi_slave_ar_id;
                  state_d  = RERR;
               end else begin
                  tx_data_d = {OPC_READ, 20'h0, 4'hF};
                  state_d   = TXCMD;
               end
            end else if (!aw_ready_q && !ar_ready_q) begin
               // Simultaneous requests alternate; prio_q low means write goes first
               if (axi_slave_aw_valid && axi_slave_ar_valid) begin
                  aw_ready_d = !prio_q;
                  ar_ready_d = prio_q;
                  prio_d     = !prio_q;
               end else begin
                  aw_ready_d = axi_slave_aw_valid;
                  ar_ready_d = axi_slave_ar_valid;
               end
            end
         end
         WDATA: begin
            if (axi_slave_w_valid) begin
               word_d    = w_shift[31:0];
               tx_data_d = {OPC_WRITE, 20'h0, strb_shift[3:0]};
               state_d   = TXCMD;
            end
         end
         TXCMD: begin
            if (tx_ready) begin
               tx_data_d = addr_q;
               state_d   = TXADDR;
            end
         end
         TXADDR: begin
            if (tx_ready) begin
               if (is_write_q) begin
                  tx_data_d = word_q;
                  state_d   = TXDATA;
               end else begin
                  tmo_d   = '0;
                  state_d = RXWAIT;
               end
            end
         end
         TXDATA: begin
            if (tx_ready) begin
               b_resp_d = RESP_OKAY;
               b_id_d   = id_q;
               state_d  = BRESP;
            end
         end
         RXWAIT: begin
            r_last_d = 1'b1;
            r_id_d   = id_q;
            if (rx_valid) begin
               r_data_d = {REPL{rx_data}};
               r_resp_d = RESP_OKAY;
               state_d  = RRESP;
            end else if (tmo_q == TMO_LAST) begin
               r_data_d = {REPL{TIMEOUT_DATA}};
               r_resp_d = RESP_SLVERR;
               state_d  = RRESP;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         BRESP: begin
            if (axi_slave_b_ready) state_d = IDLE;
         end
         RRESP: begin
            if (axi_slave_r_ready) state_d = IDLE;
         end
         WDRAIN: begin
            if (axi_slave_w_valid) begin
               if (beat_q == len_q) begin
                  b_resp_d = RESP_SLVERR;
                  b_id_d   = id_q;
                  state_d  = BRESP;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         RERR: begin
            if (axi_slave_r_ready) begin
               if (beat_q == len_q) begin
                  state_d = IDLE;
               end else begin
                  beat_d   = beat_q + 8'd1;
                  r_last_d = ((beat_q + 8'd1) == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         aw_ready_q <= 1'b0;
         ar_ready_q <= 1'b0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         id_q       <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         tmo_q      <= '0;
         word_q     <= '0;
         tx_data_q  <= '0;
         b_resp_q   <= '0;
         b_id_q     <= '0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
         r_last_q   <= 1'b0;
         r_id_q     <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         aw_ready_q <= aw_ready_d;
         ar_ready_q <= ar_ready_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         id_q       <= id_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         tmo_q      <= tmo_d;
         word_q     <= word_d;
         tx_data_q  <= tx_data_d;
         b_resp_q   <= b_resp_d;
         b_id_q     <= b_id_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         r_last_q   <= r_last_d;
         r_id_q     <= r_id_d;
      end
   end

   assign axi_slave_aw_ready = aw_ready_q;
   assign axi_slave_ar_ready = ar_ready_q;
   assign axi_slave_w_ready  = (state_q == WDATA) || (state_q == WDRAIN);
   assign axi_slave_b_valid  = (state_q == BRESP);
   assign axi_slave_b_resp   = b_resp_q;
   assign axi_slave_b_id     = b_id_q;
   assign axi_slave_b_user   = '0;
   assign axi_slave_r_valid  = (state_q == RRESP) || (state_q == RERR);
   assign axi_slave_r_data   = r_data_q;
   assign axi_slave_r_resp   = r_resp_q;
   assign axi_slave_r_last   = r_last_q;
   assign axi_slave_r_id     = r_id_q;
   assign axi_slave_r_user   = '0;
   assign tx_valid           = (state_q == TXCMD) || (state_q == TXADDR) || (state_q == TXDATA);
   assign tx_data            = tx_data_q;
   assign rx_ready           = (state_q == RXWAIT);
   assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_prvp_spi_master_axi_slave_plug.sv
// Randomized self-checking bench: AXI master + link responder against a transaction-level model.
module tb_prvp_spi_master_axi_slave_plug;

   localparam int DW  = 64;
   localparam int IW  = 3;
   localparam int UW  = 6;
   localparam int AW  = 32;
   localparam int TMO = 1024;

   logic clk = 1'b0;
   logic aresetn;
   always #5 clk = ~clk;

   logic          aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic [AW-1:0] aw_addr, ar_addr;
   logic [7:0]    aw_len, ar_len;
   logic [2:0]    aw_size, ar_size;
   logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
   logic [IW-1:0] aw_id, ar_id, b_id, r_id;
   logic [UW-1:0] aw_user, ar_user, w_user, b_user, r_user;
   logic [DW-1:0] w_data, r_data;
   logic [7:0]    w_strb;
   logic          ar_valid, ar_ready, r_valid, r_last, r_ready;
   logic [31:0]   tx_data, rx_data;
   logic          tx_valid, tx_ready, rx_valid, rx_ready, busy;

   prvp_spi_master_axi_slave_plug #(
      .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
      .AXI_ID_WIDTH(IW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .axi_aclk(clk), .axi_aresetn(aresetn),
      .axi_slave_aw_valid(aw_valid), .axi_slave_aw_addr(aw_addr), .axi_slave_aw_len(aw_len),
      .axi_slave_aw_size(aw_size), .axi_slave_aw_burst(aw_burst), .axi_slave_aw_id(aw_id),
      .axi_slave_aw_user(aw_user), .axi_slave_aw_ready(aw_ready),
      .axi_slave_w_valid(w_valid), .axi_slave_w_data(w_data), .axi_slave_w_strb(w_strb),
      .axi_slave_w_last(w_last), .axi_slave_w_user(w_user), .axi_slave_w_ready(w_ready),
      .axi_slave_b_valid(b_valid), .axi_slave_b_resp(b_resp), .axi_slave_b_id(b_id),
      .axi_slave_b_user(b_user), .axi_slave_b_ready(b_ready),
      .axi_slave_ar_valid(ar_valid), .axi_slave_ar_addr(ar_addr), .axi_slave_ar_len(ar_len),
      .axi_slave_ar_size(ar_size), .axi_slave_ar_burst(ar_burst), .axi_slave_ar_id(ar_id),
      .axi_slave_ar_user(ar_user), .axi_slave_ar_ready(ar_ready),
      .axi_slave_r_valid(r_valid), .axi_slave_r_data(r_data), .axi_slave_r_resp(r_resp),
      .axi_slave_r_last(r_last), .axi_slave_r_id(r_id), .axi_slave_r_user(r_user),
      .axi_slave_r_ready(r_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy)
   );

   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   logic [31:0] tx_q[$];
   int          tx_cyc_q[$];
   int          addr_stall = 0;
   logic        stall_pending = 1'b0;
   logic [31:0] stall_data = '0;
   bit          model_prio_write = 1'b1;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Link-side responder: random tx back-pressure, word capture, stall stability
   always @(negedge clk) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (tx_valid && tx_q.size() == 1 && addr_stall > 0) begin
         tx_ready = 1'b0;
         addr_stall--;
      end
      if (stall_pending && tx_valid) checkOutput("tx_stable", tx_data, stall_data);
      stall_pending = tx_valid && !tx_ready && aresetn;
      stall_data    = tx_data;
      if (tx_valid && tx_ready && aresetn) begin
         tx_q.push_back(tx_data);
         tx_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] lane_word(input logic [63:0] d, input logic [31:0] a);
      return 32'((d >> (32 * a[2])) & 64'h0000_0000_FFFF_FFFF);
   endfunction

   function automatic logic [3:0] lane_strb(input logic [7:0] s, input logic [31:0] a);
      return 4'((s >> (4 * a[2])) & 8'h0F);
   endfunction

   task automatic drive_idle();
      aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 1; aw_id = 0; aw_user = 0;
      ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 1; ar_id = 0; ar_user = 0;
      w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; w_user = 0;
      b_ready = 0; r_ready = 0; rx_valid = 0; rx_data = 0;
   endtask

   task automatic apply_reset();
      aresetn = 1'b0;
      drive_idle();
      repeat (3) @(negedge clk);
      aresetn = 1'b1;
      model_prio_write = 1'b1;
      tx_q.delete();
      tx_cyc_q.delete();
   endtask

   task automatic set_aw(input logic [31:0] a, input logic [IW-1:0] id, input logic [7:0] len, input logic [2:0] size);
      aw_valid = 1; aw_addr = a; aw_id = id; aw_len = len; aw_size = size; aw_user = UW'($urandom);
   endtask

   task automatic set_ar(input logic [31:0] a, input logic [IW-1:0] id, input logic [7:0] len, input logic [2:0] size);
      ar_valid = 1; ar_addr = a; ar_id = id; ar_len = len; ar_size = size; ar_user = UW'($urandom);
   endtask

   task automatic wait_aw();
      int n = 0;
      while (!aw_ready && n < 20) begin @(negedge clk); n++; end
      checkOutput("aw_ready", aw_ready, 1);
      @(negedge clk);
      aw_valid = 0;
   endtask

   task automatic wait_ar();
      int n = 0;
      while (!ar_ready && n < 20) begin @(negedge clk); n++; end
      checkOutput("ar_ready", ar_ready, 1);
      @(negedge clk);
      ar_valid = 0;
   endtask

   task automatic write_finish(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                               input logic [IW-1:0] id, input logic [7:0] len, input logic [2:0] size);
      bit err = (len != 0) || (size > 2);
      int beats = err ? len + 1 : 1;
      int n;
      for (int i = 0; i < beats; i++) begin
         w_valid = 1;
         w_data  = (i == 0) ? d : {$urandom, $urandom};
         w_strb  = s;
         w_last  = (i == beats - 1);
         n = 0;
         while (!w_ready && n < 20) begin @(negedge clk); n++; end
         checkOutput("w_ready", w_ready, 1);
         @(negedge clk);
      end
      w_valid = 0; w_last = 0;
      n = 0;
      while (!b_valid && n < 200) begin @(negedge clk); n++; end
      checkOutput("b_valid", b_valid, 1);
      checkOutput("b_resp", b_resp, err ? 2'b10 : 2'b00);
      checkOutput("b_id", b_id, id);
      b_ready = 1;
      @(negedge clk);
      b_ready = 0;
      checkOutput("busy_after_b", busy, 0);
      if (err) begin
         checkOutput("wr_err_tx_count", tx_q.size(), 0);
      end else begin
         checkOutput("wr_tx_count", tx_q.size(), 3);
         if (tx_q.size() == 3) begin
            checkOutput("wr_tx_cmd", tx_q[0], 32'h0200_0000 | lane_strb(s, a));
            checkOutput("wr_tx_addr", tx_q[1], a);
            checkOutput("wr_tx_data", tx_q[2], lane_word(d, a));
         end
      end
   endtask

   task automatic read_finish(input logic [31:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [31:0] rxd, input int delay, input bit no_rx);
      bit err = (len != 0) || (size > 2);
      int n;
      if (err) begin
         for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!r_valid && n < 50) begin @(negedge clk); n++; end
            checkOutput("rerr_valid", r_valid, 1);
            checkOutput("rerr_data", r_data, 0);
            checkOutput("rerr_resp", r_resp, 2'b10);
            checkOutput("rerr_last", r_last, i == len);
            checkOutput("rerr_id", r_id, id);
            r_ready = 1;
            @(negedge clk);
            r_ready = 0;
         end
         checkOutput("rd_err_tx_count", tx_q.size(), 0);
      end else begin
         n = 0;
         while (tx_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
         checkOutput("rd_tx_count", tx_q.size(), 2);
         if (tx_q.size() >= 2) begin
            checkOutput("rd_tx_cmd", tx_q[0], 32'h0B00_000F);
            checkOutput("rd_tx_addr", tx_q[1], a);
         end
         if (!no_rx) begin
            repeat (delay) @(negedge clk);
            rx_valid = 1; rx_data = rxd;
            n = 0;
            while (!rx_ready && n < 20) begin @(negedge clk); n++; end
            checkOutput("rx_ready", rx_ready, 1);
            @(negedge clk);
            rx_valid = 0;
         end
         n = 0;
         while (!r_valid && n < TMO + 20) begin @(negedge clk); n++; end
         checkOutput("r_valid", r_valid, 1);
         if (no_rx && tx_cyc_q.size() >= 2)
            checkOutput("timeout_latency", cyc - tx_cyc_q[1], TMO + 1);
         checkOutput("r_data", r_data, no_rx ? {32'hDEAD_BEEF, 32'hDEAD_BEEF} : {rxd, rxd});
         checkOutput("r_resp", r_resp, no_rx ? 2'b10 : 2'b00);
         checkOutput("r_last", r_last, 1);
         checkOutput("r_id", r_id, id);
         r_ready = 1;
         @(negedge clk);
         r_ready = 0;
      end
      checkOutput("busy_after_r", busy, 0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input logic [IW-1:0] id, input logic [7:0] len, input logic [2:0] size);
      tx_q.delete(); tx_cyc_q.delete();
      set_aw(a, id, len, size);
      wait_aw();
      write_finish(a, d, s, id, len, size);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [31:0] rxd, input int delay, input bit no_rx);
      tx_q.delete(); tx_cyc_q.delete();
      set_ar(a, id, len, size);
      wait_ar();
      read_finish(a, id, len, size, rxd, delay, no_rx);
   endtask

   task automatic contention();
      logic [31:0] wa = $urandom & 32'hFFFF_FFFC;
      logic [31:0] ra = $urandom & 32'hFFFF_FFFC;
      logic [63:0] wd = {$urandom, $urandom};
      logic [7:0]  ws = 8'($urandom);
      logic [IW-1:0] wid = IW'($urandom);
      logic [IW-1:0] rid = IW'($urandom);
      logic [31:0] rxd = $urandom;
      bit exp_write = model_prio_write;
      int n = 0;
      tx_q.delete(); tx_cyc_q.delete();
      set_aw(wa, wid, 0, 2);
      set_ar(ra, rid, 0, 2);
      while (!aw_ready && !ar_ready && n < 20) begin @(negedge clk); n++; end
      model_prio_write = !model_prio_write;
      checkOutput("arb_aw_ready", aw_ready, exp_write);
      checkOutput("arb_ar_ready", ar_ready, !exp_write);
      if (aw_ready) begin
         @(negedge clk); aw_valid = 0;
         write_finish(wa, wd, ws, wid, 0, 2);
         tx_q.delete(); tx_cyc_q.delete();
         wait_ar();
         read_finish(ra, rid, 0, 2, rxd, 3, 0);
      end else begin
         @(negedge clk); ar_valid = 0;
         read_finish(ra, rid, 0, 2, rxd, 3, 0);
         tx_q.delete(); tx_cyc_q.delete();
         wait_aw();
         write_finish(wa, wd, ws, wid, 0, 2);
      end
   endtask

   task automatic applyStimulus();
      logic [31:0] a = $urandom & 32'hFFFF_FFFC;
      logic [7:0]  len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
      logic [2:0]  size = ($urandom_range(0, 5) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      logic [IW-1:0] id = IW'($urandom);
      if ($urandom_range(0, 1) == 1)
         do_write(a, {$urandom, $urandom}, 8'($urandom), id, len, size);
      else
         do_read(a, id, len, size, $urandom, $urandom_range(0, 15), 0);
   endtask

   initial begin
      aresetn = 1'b0;
      drive_idle();
      apply_reset();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_aw_ready", aw_ready, 0);
      checkOutput("rst_ar_ready", ar_ready, 0);
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_b_valid", b_valid, 0);
      checkOutput("rst_r_valid", r_valid, 0);
      checkOutput("rst_tx_data", tx_data, 0);

      do_write(32'h1000_0004, {32'hA5A5_5A5A, 32'h0}, 8'hF0, 3'd5, 0, 2);
      do_read(32'h2000_0000, 3'd3, 0, 2, 32'h1234_5678, 10, 0);
      do_read(32'h3000_0008, 3'd6, 0, 2, 32'h0, 0, 1);
      do_read(32'h3000_000C, 3'd1, 0, 2, 32'hCAFE_F00D, 2, 0);
      do_write(32'h4000_0000, 64'h1111_2222_3333_4444, 8'hFF, 3'd2, 3, 2);
      do_read(32'h4000_0010, 3'd4, 1, 2, 32'h0, 0, 0);
      do_write(32'h4000_0020, 64'h5555_6666_7777_8888, 8'h0F, 3'd7, 0, 3);

      contention();
      contention();

      addr_stall = 5;
      do_write(32'h5000_0000, 64'h0123_4567_89AB_CDEF, 8'h0F, 3'd1, 0, 2);
      checkOutput("stall_consumed", addr_stall, 0);

      tx_q.delete(); tx_cyc_q.delete();
      set_ar(32'h6000_0000, 3'd2, 0, 2);
      wait_ar();
      begin
         int n = 0;
         int seen = 0;
         while (tx_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
         repeat (4) @(negedge clk);
         checkOutput("rxwait_busy", busy, 1);
         checkOutput("rxwait_rx_ready", rx_ready, 1);
         aresetn = 1'b0;
         @(negedge clk);
         checkOutput("midrst_busy", busy, 0);
         checkOutput("midrst_r_valid", r_valid, 0);
         checkOutput("midrst_rx_ready", rx_ready, 0);
         checkOutput("midrst_tx_valid", tx_valid, 0);
         checkOutput("midrst_tx_data", tx_data, 0);
         checkOutput("midrst_r_data", r_data, 0);
         aresetn = 1'b1;
         model_prio_write = 1'b1;
         repeat (30) begin @(negedge clk); if (r_valid) seen++; end
         checkOutput("no_r_after_reset", seen, 0);
      end
      do_read(32'h6000_0004, 3'd5, 0, 2, 32'h8765_4321, 1, 0);

      for (int i = 0; i < 40; i++) applyStimulus();
      contention();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
